// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and instruction classification for the multicycle controller.
// Define JUMP_EN to make j/jal legal instructions; otherwise they decode as illegal.
package ctrl_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b11000;
  localparam logic [4:0] ALU_SLL = 5'b11001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS     = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT  = 2'b10;
  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

  typedef enum logic [2:0] {C_RTYPE, C_ALUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILLEGAL} instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_conf;
    logic       sign;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_t;

  function automatic instr_class_e classify(input logic [5:0] op, input logic [5:0] funct);
    instr_class_e c;
    c = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: c = C_RTYPE;
          default: c = C_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: c = C_ALUI;
      OP_LW:  c = C_LW;
      OP_SW:  c = C_SW;
      OP_BEQ: c = C_BEQ;
`ifdef JUMP_EN
      OP_J:   c = C_J;
      OP_JAL: c = C_JAL;
`endif
      default: c = C_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_conf_decode.sv
// Execute-stage ALU setup decoded from OpCode/Funct; instructions without an ALU op yield all zeros.
module alu_conf_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output logic [4:0] alu_conf,
  output logic       sign,
  output logic       ext_op,
  output logic       lui_op,
  output logic [1:0] alu_src_a
);

  always_comb begin
    alu_conf  = ALU_ADD;
    sign      = 1'b0;
    ext_op    = 1'b0;
    lui_op    = 1'b0;
    alu_src_a = SRC_A_PC;
    case (op_code)
      OP_RTYPE: begin
        alu_src_a = SRC_A_RS;
        case (funct)
          FN_ADD, FN_ADDU: alu_conf = ALU_ADD;
          FN_SUB, FN_SUBU: alu_conf = ALU_SUB;
          FN_AND:          alu_conf = ALU_AND;
          FN_OR:           alu_conf = ALU_OR;
          FN_XOR:          alu_conf = ALU_XOR;
          FN_NOR:          alu_conf = ALU_NOR;
          FN_SLT: begin
            alu_conf = ALU_SLT;
            sign     = 1'b1;
          end
          FN_SLTU:         alu_conf = ALU_SLT;
          // Shifts feed shamt into In1 and the register data into In2.
          FN_SLL: begin
            alu_conf  = ALU_SLL;
            alu_src_a = SRC_A_SHAMT;
          end
          FN_SRL: begin
            alu_conf  = ALU_SRL;
            alu_src_a = SRC_A_SHAMT;
          end
          FN_SRA: begin
            alu_conf  = ALU_SRA;
            alu_src_a = SRC_A_SHAMT;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        alu_src_a = SRC_A_RS;
        ext_op    = 1'b1;
      end
      OP_ANDI: begin
        alu_src_a = SRC_A_RS;
        alu_conf  = ALU_AND;
      end
      OP_SLTI: begin
        alu_src_a = SRC_A_RS;
        alu_conf  = ALU_SLT;
        sign      = 1'b1;
        ext_op    = 1'b1;
      end
      OP_SLTIU: begin
        alu_src_a = SRC_A_RS;
        alu_conf  = ALU_SLT;
        ext_op    = 1'b1;
      end
      OP_LUI: begin
        alu_src_a = SRC_A_RS;
        lui_op    = 1'b1;
      end
      OP_BEQ: begin
        alu_src_a = SRC_A_RS;
        alu_conf  = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle MIPS controller: IF/ID/EX/MEM/WB sequencing with per-state output decode.
// Define JUMP_EN (see ctrl_pkg) to enable j/jal; otherwise opcodes 02/03 raise Illegal.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUConf,
  output logic       Sign,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] PCSource,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       Illegal
);

  state_e       state, state_next;
  instr_class_e iclass;
  ctrl_t        ctl, ctl_out;
  logic [4:0]   dec_conf;
  logic         dec_sign, dec_ext, dec_lui;
  logic [1:0]   dec_src_a;
  logic         unused_zero;

  // Branch qualification (PCWriteCond & Zero) is done in the datapath.
  assign unused_zero = Zero;
  assign iclass = classify(OpCode, Funct);

  alu_conf_decode u_alu_conf_decode (
    .op_code   (OpCode),
    .funct     (Funct),
    .alu_conf  (dec_conf),
    .sign      (dec_sign),
    .ext_op    (dec_ext),
    .lui_op    (dec_lui),
    .alu_src_a (dec_src_a)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    ctl        = '0;
    case (state)
      S_IF: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.pc_write  = 1'b1;
        ctl.alu_src_a = SRC_A_PC;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.alu_conf  = ALU_ADD;
        ctl.pc_source = PC_SRC_ALU;
        state_next    = S_ID;
      end
      S_ID: begin
        ctl.alu_src_a = SRC_A_PC;
        ctl.alu_src_b = SRC_B_IMM_SH;
        ctl.ext_op    = 1'b1;
        ctl.alu_conf  = ALU_ADD;
        if (iclass == C_ILLEGAL) ctl.illegal = 1'b1;
        else                     state_next  = S_EX;
      end
      S_EX: begin
        ctl.alu_conf  = dec_conf;
        ctl.sign      = dec_sign;
        ctl.ext_op    = dec_ext;
        ctl.lui_op    = dec_lui;
        ctl.alu_src_a = dec_src_a;
        case (iclass)
          C_RTYPE: begin
            ctl.alu_src_b = SRC_B_RT;
            state_next    = S_WB;
          end
          C_ALUI: begin
            ctl.alu_src_b = SRC_B_IMM;
            state_next    = S_WB;
          end
          C_LW, C_SW: begin
            ctl.alu_src_b = SRC_B_IMM;
            state_next    = S_MEM;
          end
          C_BEQ: begin
            ctl.alu_src_b     = SRC_B_RT;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = PC_SRC_ALUOUT;
          end
          C_J: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PC_SRC_JUMP;
          end
          C_JAL: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_source  = PC_SRC_JUMP;
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = DST_RA;
            ctl.mem_to_reg = M2R_PC;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d = 1'b1;
        if (iclass == C_LW) begin
          ctl.mem_read = 1'b1;
          state_next   = S_WB;
        end else begin
          ctl.mem_write = 1'b1;
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        if (iclass == C_LW)         ctl.mem_to_reg = M2R_MDR;
        else if (iclass == C_RTYPE) ctl.reg_dst    = DST_RD;
      end
      default: ;
    endcase
  end

  // State is already IF during reset, so the enables must be masked combinationally.
  always_comb begin
    ctl_out = ctl;
    if (!reset) begin
      ctl_out.pc_write      = 1'b0;
      ctl_out.pc_write_cond = 1'b0;
      ctl_out.ir_write      = 1'b0;
      ctl_out.mem_write     = 1'b0;
      ctl_out.reg_write     = 1'b0;
      ctl_out.illegal       = 1'b0;
    end
  end

  assign PCWrite     = ctl_out.pc_write;
  assign PCWriteCond = ctl_out.pc_write_cond;
  assign IRWrite     = ctl_out.ir_write;
  assign MemRead     = ctl_out.mem_read;
  assign MemWrite    = ctl_out.mem_write;
  assign RegWrite    = ctl_out.reg_write;
  assign IorD        = ctl_out.i_or_d;
  assign ALUSrcA     = ctl_out.alu_src_a;
  assign ALUSrcB     = ctl_out.alu_src_b;
  assign ALUConf     = ctl_out.alu_conf;
  assign Sign        = ctl_out.sign;
  assign ExtOp       = ctl_out.ext_op;
  assign LuiOp       = ctl_out.lui_op;
  assign PCSource    = ctl_out.pc_source;
  assign RegDst      = ctl_out.reg_dst;
  assign MemtoReg    = ctl_out.mem_to_reg;
  assign Illegal     = ctl_out.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions against a per-instruction
// table of expected output vectors, including resets dropped into the middle of instructions.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw, pcwc, irw, mrd, mwr, rgw, iord;
    logic [1:0] srca, srcb;
    logic [4:0] conf;
    logic       sgn, ext, lui;
    logic [1:0] pcsrc, rdst, m2r;
    logic       ill;
  } exp_t;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_JAL = 7;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       Zero;
  logic       PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, IorD;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg;
  logic [4:0] ALUConf;
  logic       Sign, ExtOp, LuiOp, Illegal;

  exp_t dut_now;
  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  logic [5:0] op_pool [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
  logic [5:0] fn_pool [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .Zero        (Zero),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IRWrite     (IRWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .IorD        (IorD),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUConf     (ALUConf),
    .Sign        (Sign),
    .ExtOp       (ExtOp),
    .LuiOp       (LuiOp),
    .PCSource    (PCSource),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .Illegal     (Illegal)
  );

  assign dut_now = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, IorD,
                    ALUSrcA, ALUSrcB, ALUConf, Sign, ExtOp, LuiOp, PCSource, RegDst, MemtoReg, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [25:0] actual, input logic [25:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %07b_%02b_%02b_%05b_%03b_%02b_%02b_%02b_%01b expected %07b_%02b_%02b_%05b_%03b_%02b_%02b_%02b_%01b",
               tag, actual[25:19], actual[18:17], actual[16:15], actual[14:10], actual[9:7], actual[6:5],
               actual[4:3], actual[2:1], actual[0], expected[25:19], expected[18:17], expected[16:15],
               expected[14:10], expected[9:7], expected[6:5], expected[4:3], expected[2:1], expected[0]);
    end
  endtask

  function automatic exp_t if_vec();
    exp_t e;
    e = '0;
    e.pcw  = 1'b1;
    e.irw  = 1'b1;
    e.mrd  = 1'b1;
    e.srcb = 2'b01;
    return e;
  endfunction

  // Expected output vector for every cycle of one instruction, straight from the instruction table.
  task automatic build_expected(input logic [5:0] op, input logic [5:0] fn);
    exp_t       e;
    int         kind;
    logic [4:0] conf;
    logic       sgn, ext, lui, shift;
    kind = K_ILL; conf = 5'b00000; sgn = 1'b0; ext = 1'b0; lui = 1'b0; shift = 1'b0;
    if (op == 6'h00) begin
      kind = K_R;
      case (fn)
        6'h20, 6'h21: conf = 5'b00000;
        6'h22, 6'h23: conf = 5'b00110;
        6'h24: conf = 5'b00010;
        6'h25: conf = 5'b00001;
        6'h26: conf = 5'b01101;
        6'h27: conf = 5'b01100;
        6'h2A: begin conf = 5'b00111; sgn = 1'b1; end
        6'h2B: conf = 5'b00111;
        6'h00: begin conf = 5'b11001; shift = 1'b1; end
        6'h02: begin conf = 5'b10000; shift = 1'b1; end
        6'h03: begin conf = 5'b11000; shift = 1'b1; end
        default: kind = K_ILL;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin kind = K_I; ext = 1'b1; end
        6'h0C: begin kind = K_I; conf = 5'b00010; end
        6'h0A: begin kind = K_I; conf = 5'b00111; sgn = 1'b1; ext = 1'b1; end
        6'h0B: begin kind = K_I; conf = 5'b00111; ext = 1'b1; end
        6'h0F: begin kind = K_I; lui = 1'b1; end
        6'h23: begin kind = K_LW; ext = 1'b1; end
        6'h2B: begin kind = K_SW; ext = 1'b1; end
        6'h04: begin kind = K_BEQ; conf = 5'b00110; end
`ifdef JUMP_EN
        6'h02: kind = K_J;
        6'h03: kind = K_JAL;
`endif
        default: kind = K_ILL;
      endcase
    end
    exp_q.delete();
    exp_q.push_back(if_vec());
    e = '0; e.srcb = 2'b11; e.ext = 1'b1; e.ill = (kind == K_ILL);
    exp_q.push_back(e);
    if (kind == K_ILL) return;
    e = '0;
    case (kind)
      K_R, K_I, K_LW, K_SW: begin
        e.srca = shift ? 2'b10 : 2'b01;
        e.srcb = (kind == K_R) ? 2'b00 : 2'b10;
        e.conf = conf; e.sgn = sgn; e.ext = ext; e.lui = lui;
      end
      K_BEQ: begin
        e.srca = 2'b01; e.srcb = 2'b00; e.conf = conf; e.pcwc = 1'b1; e.pcsrc = 2'b01;
      end
      default: begin
        e.pcw = 1'b1; e.pcsrc = 2'b10;
        if (kind == K_JAL) begin e.rgw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10; end
      end
    endcase
    exp_q.push_back(e);
    e = '0;
    if (kind == K_LW) begin e.mrd = 1'b1; e.iord = 1'b1; exp_q.push_back(e); end
    if (kind == K_SW) begin e.mwr = 1'b1; e.iord = 1'b1; exp_q.push_back(e); end
    e = '0;
    if (kind == K_R)  begin e.rgw = 1'b1; e.rdst = 2'b01; exp_q.push_back(e); end
    if (kind == K_I)  begin e.rgw = 1'b1; exp_q.push_back(e); end
    if (kind == K_LW) begin e.rgw = 1'b1; e.m2r = 2'b01; exp_q.push_back(e); end
  endtask

  // Entered and left at a falling edge while the controller sits in IF.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input int abort_at);
    logic [5:0] enables;
    build_expected(op, fn);
    OpCode = op;
    Funct  = fn;
    Zero   = z;
    foreach (exp_q[i]) begin
      #1 checkOutput($sformatf("op%02h fn%02h z%0b cyc%0d", op, fn, z, i), dut_now, exp_q[i]);
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1 enables = {PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, Illegal};
        checkOutput($sformatf("op%02h abort cyc%0d enables", op, i), 26'(enables), 26'd0);
        @(posedge clk);
        #1 enables = {PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, Illegal};
        checkOutput($sformatf("op%02h reset held enables", op), 26'(enables), 26'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] enables;
    logic [5:0] op, fn;
    int         abort_at;
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h20; Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1 enables = {PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, Illegal};
    checkOutput("power-on reset enables", 26'(enables), 26'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(6'h00, 6'h2A, 1'b0, -1);
    applyStimulus(6'h00, 6'h03, 1'b1, -1);
    applyStimulus(6'h00, 6'h00, 1'b0, -1);
    applyStimulus(6'h23, 6'h11, 1'b0, -1);
    applyStimulus(6'h04, 6'h00, 1'b1, -1);
    applyStimulus(6'h04, 6'h00, 1'b0, -1);
    applyStimulus(6'h3F, 6'h20, 1'b0, -1);
    applyStimulus(6'h03, 6'h00, 1'b0, -1);
    applyStimulus(6'h02, 6'h00, 1'b0, -1);
    applyStimulus(6'h2B, 6'h00, 1'b0, 3);
    applyStimulus(6'h0F, 6'h00, 1'b0, -1);
    applyStimulus(6'h0C, 6'h00, 1'b0, -1);
    applyStimulus(6'h0B, 6'h00, 1'b0, -1);
    applyStimulus(6'h00, 6'h08, 1'b0, -1);
    applyStimulus(6'h23, 6'h00, 1'b0, 2);

    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 14)];
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(op, fn, 1'($urandom), abort_at);
    end

    #1 checkOutput("final IF", dut_now, if_vec());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the following ports (clock and reset first):
  clk       in   1  single system clock; all state changes on rising edge
  reset     in   1  asynchronous, active-low reset
  OpCode    in   6  instruction[31:26] from the external instruction register
  Funct     in   6  instruction[5:0]
  Zero      in   1  ALU zero flag (Result == 0)
  PCWrite   out  1  unconditional PC write enable
  PCWriteCond out 1 PC write enable, qualified by Zero (beq)
  IRWrite   out  1  instruction register load
  MemRead   out  1  memory read strobe
  MemWrite  out  1  memory write strobe
  RegWrite  out  1  register file write enable
  IorD      out  1  0 = PC address, 1 = ALUOut address
  ALUSrcA   out  2  00 PC, 01 rs, 10 shamt
  ALUSrcB   out  2  00 rt, 01 const 4, 10 imm ext, 11 imm ext<<2
  ALUConf   out  5  ALU operation code
  Sign      out  1  signed compare select
  ExtOp     out  1  1 = sign-extend immediate, 0 = zero-extend
  LuiOp     out  1  immediate shifted to upper half
  PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
  RegDst    out  2  00 rt, 01 rd, 10 $31
  MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
  Illegal   out  1  one-cycle pulse on unsupported opcode/funct
REQ-002 ALUConf encodings SHALL be: ADD 00000, OR 00001, AND 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SRL 10000, SRA 11000, SLL 11001; shifts take shamt on ALU In1, data on In2.

Function
REQ-003 The block SHALL be a Moore FSM with states IF, ID, EX, MEM, WB; outputs decode from state plus OpCode/Funct; unlisted outputs are 0.
REQ-004 IF SHALL assert MemRead, IRWrite, PCWrite with IorD=0, ALUSrcA=00, ALUSrcB=01, ALUConf=ADD, PCSource=00; next state ID.
REQ-005 ID SHALL drive ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUConf=ADD (branch target into ALUOut); next state EX.
REQ-006 R-type (OpCode 0) EX SHALL map Funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT Sign=1, 2B SLT Sign=0, 00 SLL, 02 SRL, 03 SRA (shifts ALUSrcA=10, others 01; ALUSrcB=00); then WB with RegDst=01, MemtoReg=00, RegWrite=1.
REQ-007 I-type EX SHALL use ALUSrcA=01, ALUSrcB=10: addi/addiu(08/09) ADD ExtOp=1; andi(0C) AND ExtOp=0; slti(0A) SLT Sign=1; sltiu(0B) SLT Sign=0 ExtOp=1; lui(0F) ADD LuiOp=1; then WB with RegDst=00.
REQ-008 lw(23): EX ADD ExtOp=1 -> MEM (MemRead, IorD=1) -> WB (RegDst=00, MemtoReg=01, RegWrite); 5 cycles total.
REQ-009 sw(2B): EX ADD -> MEM (MemWrite, IorD=1) -> IF; 4 cycles.
REQ-010 beq(04): EX SHALL drive ALUSrcA=01, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01 -> IF; 3 cycles; PC update happens only when Zero=1 (external AND).
REQ-011 Unsupported OpCode/Funct SHALL pulse Illegal for one cycle in ID and return to IF with no write enable asserted.
REQ-012 Latency per instruction: beq/j/jal 3 (jump 3 via EX), R/I/sw 4, lw 5; WB and terminal states always return to IF.

Reset
REQ-013 reset low SHALL force state IF asynchronously; while reset is low every write enable and Illegal SHALL be 0; the first IF fetch occurs on the first rising edge after reset deasserts.
REQ-014 Reset asserted mid-instruction SHALL abandon it with no further register or memory write.

Configuration
REQ-015 With JUMP_EN defined, j(02) EX SHALL assert PCWrite, PCSource=10 -> IF, and jal(03) additionally RegWrite, RegDst=10, MemtoReg=10 in the same EX cycle; without JUMP_EN, OpCodes 02/03 SHALL be treated as Illegal per REQ-011.

Structure
REQ-016 A shared package ctrl_pkg SHALL hold ALUConf codes, OpCode/Funct constants, and the state enumeration.
REQ-017 The combinational OpCode/Funct -> {ALUConf, Sign, ExtOp, LuiOp, ALUSrcA} map SHALL be a sub-module alu_conf_decode; the FSM stays in multicycle_ctrl.

Verification
REQ-018 Reset low mid-MEM of sw -> MemWrite 0 immediately, state IF; release -> IF outputs next cycle.
REQ-019 OpCode 00 Funct 2A -> EX ALUConf=00111 Sign=1; Funct 03 -> ALUConf=11000 ALUSrcA=10; WB RegWrite=1 RegDst=01.
REQ-020 lw (OpCode 23) -> IF,ID,EX,MEM,WB in 5 cycles; MEM MemRead=1 IorD=1; WB MemtoReg=01.
REQ-021 beq with Zero=1 and Zero=0 -> EX PCWriteCond=1 ALUConf=00110 both cases; next state IF after 3 cycles.
REQ-022 OpCode 3F -> Illegal=1 exactly one cycle, no write enables, back to IF; OpCode 03 with and without JUMP_EN -> jal writeback vs Illegal.
